// File: rtl/bike_banked_ram.sv
// bike_banked_ram: BIKE polynomial store with a 32-bit lane port, a B_WIDTH word port and a zeroize sequencer.
// Latency: reads return 1 cycle after the strobe, or 2 when BIKE_RAM_OUTREG_EN is defined. Writes land at the strobe edge.
// Backpressure: none. Strobes are dropped while busy, and strobes on the unselected port are dropped.
module bike_banked_ram #(
    parameter int B_WIDTH = 128,
    parameter int R_BITS  = 12323,
    localparam int LANES  = B_WIDTH / 32,
    localparam int DEPTH  = (R_BITS + B_WIDTH - 1) / B_WIDTH,
    localparam int AW     = $clog2(DEPTH),
    localparam int SAW    = $clog2(DEPTH * LANES)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               sampling,
    input  logic               wen_samp,
    input  logic               ren_samp,
    input  logic [SAW-1:0]     addr_samp,
    input  logic [31:0]        din_samp,
    output logic [31:0]        dout_samp,
    output logic               valid_samp,
    input  logic               wen,
    input  logic               ren,
    input  logic [AW-1:0]      addr,
    input  logic [B_WIDTH-1:0] din,
    output logic [B_WIDTH-1:0] dout,
    output logic               valid,
    input  logic               clear,
    output logic               busy,
    output logic               done
);

    localparam int LOG2L = $clog2(LANES);
    localparam int LW    = (LANES > 1) ? LOG2L : 1;
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t  state;
    logic [AW-1:0] cnt;

    logic [LANES-1:0][31:0] mem [DEPTH];
    logic [LANES-1:0][31:0] rd_data;
    logic [LW-1:0]          rd_lane;
    logic                   rd_vw;
    logic                   rd_vs;

    logic [AW-1:0] samp_word;
    logic [LW-1:0] samp_lane;
    logic          samp_in;
    logic          wide_in;
    logic          idle;

    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [LANES-1:0]       wr_lanes;
    logic [LANES-1:0][31:0] wr_data;

    logic          rd_en_w;
    logic          rd_en_s;
    logic          rd_in;
    logic [AW-1:0] rd_addr;

    logic [B_WIDTH-1:0] wide_mux;
    logic [31:0]        samp_mux;

    assign idle      = (state == IDLE);
    assign samp_word = AW'(addr_samp >> LOG2L);
    assign samp_lane = LW'(addr_samp % LANES);
    assign samp_in   = ({1'b0, samp_word} < DEPTH_W);
    assign wide_in   = ({1'b0, addr} < DEPTH_W);

    // Only one port owns the array at a time, so a single read path serves both.
    assign rd_en_w = idle & ~sampling & ren;
    assign rd_en_s = idle & sampling & ren_samp;
    assign rd_addr = sampling ? samp_word : addr;
    assign rd_in   = sampling ? samp_in : wide_in;

    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_lanes = '0;
        wr_data  = '0;
        if (state == CLEAR) begin
            wr_en    = 1'b1;
            wr_addr  = cnt;
            wr_lanes = '1;
        end else if (sampling) begin
            if (wen_samp && samp_in) begin
                wr_en              = 1'b1;
                wr_addr            = samp_word;
                wr_lanes[samp_lane] = 1'b1;
                wr_data            = {LANES{din_samp}};
            end
        end else if (wen && wide_in) begin
            wr_en    = 1'b1;
            wr_addr  = addr;
            wr_lanes = '1;
            wr_data  = din;
        end
    end

    // Array and read register carry no reset; read-before-write falls out of the NBA ordering.
    always_ff @(posedge clk) begin
        if (rd_en_w || rd_en_s) begin
            rd_data <= rd_in ? mem[rd_addr] : '0;
        end
        if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_lanes[l]) begin
                    mem[wr_addr][l] <= wr_data[l];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_vw   <= 1'b0;
            rd_vs   <= 1'b0;
            rd_lane <= '0;
        end else begin
            rd_vw <= rd_en_w;
            rd_vs <= rd_en_s;
            if (rd_en_s) begin
                rd_lane <= samp_lane;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are masked to zero unless they carry an accepted read.
    assign wide_mux = rd_vw ? rd_data : '0;
    assign samp_mux = rd_vs ? rd_data[rd_lane] : '0;

`ifdef BIKE_RAM_OUTREG_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout       <= '0;
            dout_samp  <= '0;
            valid      <= 1'b0;
            valid_samp <= 1'b0;
        end else begin
            dout       <= wide_mux;
            dout_samp  <= samp_mux;
            valid      <= rd_vw;
            valid_samp <= rd_vs;
        end
    end
`else
    assign dout       = wide_mux;
    assign dout_samp  = samp_mux;
    assign valid      = rd_vw;
    assign valid_samp = rd_vs;
`endif

endmodule

// File: tb/tb_bike_banked_ram.sv
// Bench for bike_banked_ram: table-driven port vectors with a latency-aware scoreboard plus zeroize/reset sequences.
module tb_bike_banked_ram;

    localparam int DEPTH = 97;
`ifdef BIKE_RAM_OUTREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    logic         clk;
    logic         resetn;
    logic         sampling;
    logic         wen_samp;
    logic         ren_samp;
    logic [8:0]   addr_samp;
    logic [31:0]  din_samp;
    logic [31:0]  dout_samp;
    logic         valid_samp;
    logic         wen;
    logic         ren;
    logic [6:0]   addr;
    logic [127:0] din;
    logic [127:0] dout;
    logic         valid;
    logic         clear;
    logic         busy;
    logic         done;

    bike_banked_ram #(.B_WIDTH(128), .R_BITS(12323)) dut (
        .clk(clk), .resetn(resetn), .sampling(sampling),
        .wen_samp(wen_samp), .ren_samp(ren_samp), .addr_samp(addr_samp),
        .din_samp(din_samp), .dout_samp(dout_samp), .valid_samp(valid_samp),
        .wen(wen), .ren(ren), .addr(addr), .din(din), .dout(dout), .valid(valid),
        .clear(clear), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        logic [127:0] data;
    } exp_t;

    typedef struct {
        logic         smp;
        logic         wen;
        logic         ren;
        logic [6:0]   addr;
        logic [127:0] din;
        logic         swen;
        logic         sren;
        logic [8:0]   saddr;
        logic [31:0]  sdin;
        logic         ew;
        logic [127:0] xw;
        logic         es;
        logic [31:0]  xs;
    } vec_t;

    exp_t qw[$];
    exp_t qs[$];
    logic [3:0][31:0] shadow [DEPTH];
    int total = 0;
    int bad = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Every cycle either the head of a queue is due, or that port must show nothing.
    always @(negedge clk) begin
        if (qw.size() > 0 && qw[0].due == cyc) begin
            chk("wide_valid", 128'(valid), 128'd1);
            chk("wide_data", dout, qw[0].data);
            void'(qw.pop_front());
        end else begin
            chk("wide_quiet_valid", 128'(valid), 128'd0);
            chk("wide_quiet_dout", dout, 128'd0);
        end
        if (qs.size() > 0 && qs[0].due == cyc) begin
            chk("samp_valid", 128'(valid_samp), 128'd1);
            chk("samp_data", 128'(dout_samp), qs[0].data);
            void'(qs.pop_front());
        end else begin
            chk("samp_quiet_valid", 128'(valid_samp), 128'd0);
            chk("samp_quiet_dout", 128'(dout_samp), 128'd0);
        end
    end

    function automatic logic [127:0] pat(int w);
        logic [127:0] p;
        for (int k = 0; k < 4; k++) p[k*32 +: 32] = 32'hC000_0000 | 32'(w << 8) | 32'(k);
        return p;
    endfunction

    function automatic vec_t mk(logic smp, logic wen_i, logic ren_i, logic [6:0] a, logic [127:0] d,
                                logic swen_i, logic sren_i, logic [8:0] sa, logic [31:0] sd,
                                logic ew, logic [127:0] xw, logic es, logic [31:0] xs);
        vec_t v;
        v.smp = smp; v.wen = wen_i; v.ren = ren_i; v.addr = a; v.din = d;
        v.swen = swen_i; v.sren = sren_i; v.saddr = sa; v.sdin = sd;
        v.ew = ew; v.xw = xw; v.es = es; v.xs = xs;
        return v;
    endfunction

    task automatic idle_strobes();
        wen = 1'b0; ren = 1'b0; wen_samp = 1'b0; ren_samp = 1'b0; clear = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        sampling = v.smp; wen = v.wen; ren = v.ren; addr = v.addr; din = v.din;
        wen_samp = v.swen; ren_samp = v.sren; addr_samp = v.saddr; din_samp = v.sdin;
        if (v.ew) begin e.due = cyc + RD_LAT; e.data = v.xw; qw.push_back(e); end
        if (v.es) begin e.due = cyc + RD_LAT; e.data = {96'b0, v.xs}; qs.push_back(e); end
        if (!v.smp && v.wen && v.addr < 7'(DEPTH)) shadow[v.addr] = v.din;
        if (v.smp && v.swen && v.saddr[8:2] < 7'(DEPTH)) shadow[v.saddr[8:2]][v.saddr[1:0]] = v.sdin;
        @(posedge clk); #1;
        idle_strobes();
    endtask

    task automatic drain();
        repeat (RD_LAT + 2) @(posedge clk);
        #1;
        chk("drain_wide", 128'(qw.size()), 128'd0);
        chk("drain_samp", 128'(qs.size()), 128'd0);
    endtask

    task automatic fill(input bit inv);
        logic [127:0] p;
        for (int w = 0; w < DEPTH; w++) begin
            p = pat(w);
            if (inv) p = ~p;
            apply(mk(0, '1, '0, 7'(w), p, '0, '0, '0, '0, '0, '0, '0, '0));
        end
    endtask

    task automatic sweep();
        for (int w = 0; w < DEPTH; w++)
            apply(mk(0, '0, '1, 7'(w), '0, '0, '0, '0, '0, '1, shadow[w], '0, '0));
        drain();
    endtask

    task automatic pulse_clear();
        sampling = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    vec_t tv[$];
    logic [127:0] x1, p0, p2, p3, p4, dd;

    initial begin
        resetn = 1'b0; sampling = 1'b0; addr = '0; din = '0; addr_samp = '0; din_samp = '0;
        idle_strobes();
        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_valid", 128'(valid), 128'd0);
        chk("rst_valid_samp", 128'(valid_samp), 128'd0);
        chk("rst_dout", dout, 128'd0);
        chk("rst_dout_samp", 128'(dout_samp), 128'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        fill(1'b0);

        x1 = pat(1); x1[95:64] = 32'hA5A5_0001;
        p0 = pat(0); p2 = pat(2); p3 = pat(3); p4 = pat(4);
        dd = 128'hD00D_0003_D00D_0002_D00D_0001_D00D_0000;
        tv.push_back(mk(1, '0, '0, 7'd0, '0, '1, '0, 9'd6, 32'hA5A5_0001, '0, '0, '0, '0));
        tv.push_back(mk(0, '0, '1, 7'd1, '0, '0, '0, '0, '0, '1, x1, '0, '0));
        tv.push_back(mk(0, '1, '0, 7'd5, {32'h4, 32'h3, 32'h2, 32'h1}, '0, '0, '0, '0, '0, '0, '0, '0));
        tv.push_back(mk(1, '0, '0, 7'd0, '0, '0, '1, 9'd20, '0, '0, '0, '1, 32'h1));
        tv.push_back(mk(1, '0, '0, 7'd0, '0, '0, '1, 9'd21, '0, '0, '0, '1, 32'h2));
        tv.push_back(mk(1, '0, '0, 7'd0, '0, '0, '1, 9'd22, '0, '0, '0, '1, 32'h3));
        tv.push_back(mk(1, '0, '0, 7'd0, '0, '0, '1, 9'd23, '0, '0, '0, '1, 32'h4));
        tv.push_back(mk(1, '1, '0, 7'd0, '1, '0, '0, '0, '0, '0, '0, '0, '0));
        tv.push_back(mk(0, '0, '1, 7'd0, '0, '0, '0, '0, '0, '1, p0, '0, '0));
        tv.push_back(mk(0, '1, '1, 7'd2, dd, '0, '0, '0, '0, '1, p2, '0, '0));
        tv.push_back(mk(0, '0, '1, 7'd2, '0, '0, '0, '0, '0, '1, dd, '0, '0));
        tv.push_back(mk(0, '0, '0, 7'd0, '0, '1, '1, 9'd12, 32'hDEAD_BEEF, '0, '0, '0, '0));
        tv.push_back(mk(1, '0, '1, 7'd3, '0, '0, '1, 9'd12, '0, '0, '0, '1, p3[31:0]));
        tv.push_back(mk(1, '0, '0, 7'd0, '0, '1, '1, 9'd13, 32'h77, '0, '0, '1, p3[63:32]));
        tv.push_back(mk(1, '0, '0, 7'd0, '0, '0, '1, 9'd13, '0, '0, '0, '1, 32'h77));
        tv.push_back(mk(0, '0, '1, 7'd100, '0, '0, '0, '0, '0, '1, '0, '0, '0));
        tv.push_back(mk(0, '1, '0, 7'd100, '1, '0, '0, '0, '0, '0, '0, '0, '0));
        tv.push_back(mk(1, '0, '0, 7'd0, '0, '0, '1, 9'd400, '0, '0, '0, '1, 32'h0));
        tv.push_back(mk(0, '0, '1, 7'd4, '0, '0, '0, '0, '0, '1, p4, '0, '0));
        tv.push_back(mk(1, '0, '0, 7'd0, '0, '0, '1, 9'd16, '0, '0, '0, '1, p4[31:0]));
        for (int i = 0; i < tv.size(); i++) apply(tv[i]);
        drain();
        sweep();

        // Zeroize with a read accepted just before clear and strobes fired while busy.
        apply(mk(0, '0, '1, 7'd7, '0, '0, '0, '0, '0, '1, shadow[7], '0, '0));
        pulse_clear();
        for (int k = 0; k < DEPTH; k++) begin
            if (k == 3)  begin wen = 1'b1; ren = 1'b1; addr = 7'd96; din = '1; end
            if (k == 50) clear = 1'b1;
            if (k == 90) begin wen = 1'b1; ren = 1'b1; addr = 7'd0; din = '1; end
            if (k == 91) begin sampling = 1'b1; wen_samp = 1'b1; ren_samp = 1'b1; addr_samp = 9'd4; din_samp = '1; end
            @(negedge clk);
            chk("zero_busy", 128'(busy), 128'd1);
            chk("zero_done_early", 128'(done), 128'd0);
            @(posedge clk); #1;
            idle_strobes();
            sampling = 1'b0;
        end
        @(negedge clk);
        chk("zero_busy_end", 128'(busy), 128'd0);
        chk("zero_done", 128'(done), 128'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("zero_done_once", 128'(done), 128'd0);
        @(posedge clk); #1;
        for (int w = 0; w < DEPTH; w++) shadow[w] = '0;
        sweep();

        // Reset while the sequencer is at word 40.
        fill(1'b1);
        pulse_clear();
        repeat (40) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_mid_busy", 128'(busy), 128'd0);
        chk("rst_mid_done", 128'(done), 128'd0);
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_mid_no_done", 128'(done), 128'd0);
            chk("rst_mid_idle", 128'(busy), 128'd0);
        end
        @(posedge clk); #1;
        for (int w = 0; w < 40; w++) shadow[w] = '0;
        sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bike_banked_ram.md
# bike_banked_ram

Parametrised single-clock memory for the BIKE datapath. It stores one R_BITS polynomial as DEPTH words of B_WIDTH bits and exposes two ports: a 32-bit sampling port for lane-granular access during sampling, and a B_WIDTH scalable port for full-word access during arithmetic. It adds per-lane write enables, read-valid tracking and a hardware zeroize sequencer for wiping secret data after use. It sits between the sampler/arithmetic units and the polynomial storage.

## Interface
- B_WIDTH, 128, wide-port width; power of two, ≥ 32
- R_BITS, 12323, polynomial length in bits
- LANES, B_WIDTH/32, 32-bit lanes per word (derived)
- DEPTH, ceil(R_BITS/B_WIDTH), wide words stored (derived)
- AW, $clog2(DEPTH), wide address width (derived)
- SAW, $clog2(DEPTH*LANES), sampling address width (derived)

Ports:
- clk  in  1  clock; the only clock.
- resetn  in  1  asynchronous, active-low reset.
- sampling  in  1  1 = sampling port owns the memory; 0 = scalable port owns it.
- wen_samp / ren_samp  in  1  sampling write / read strobes.
- addr_samp  in  SAW  lane address: [SAW-1:log2(LANES)] = word, [log2(LANES)-1:0] = lane.
- din_samp  in  32  sampling write data.
- dout_samp  out  32  sampling read data.
- valid_samp  out  1  dout_samp holds the data for an accepted read.
- wen / ren  in  1  wide write / read strobes.
- addr  in  AW  wide word address.
- din  in  B_WIDTH  wide write data; lane k = bits [32k+31:32k].
- dout  out  B_WIDTH  wide read data.
- valid  out  1  dout holds the data for an accepted read.
- clear  in  1  zeroize request; a one-cycle pulse is sufficient.
- busy  out  1  zeroize in progress.
- done  out  1  one-cycle pulse when a zeroize completes.

## Operation
- FSM states: IDLE and CLEAR. IDLE→CLEAR on clear=1. CLEAR writes all-zero to word cnt, then increments cnt. CLEAR→IDLE after word DEPTH-1 is written. done pulses in the cycle after the last write.
- clear while busy=1: ignored.
- While busy=1: all port strobes are ignored, valid and valid_samp stay 0, and no read is accepted.
- Port selection (IDLE only): sampling=1 accepts only wen_samp and ren_samp. sampling=0 accepts only wen and ren. The non-selected port's strobes are dropped with no side effects.
- Sampling write: updates only the addressed lane of the addressed word; the other lanes are preserved through the per-lane write enable.
- Wide write: updates all LANES lanes.
- Same-cycle read and write to the same location: read-first, returning the old data.
- Out-of-range address (word ≥ DEPTH): the write is ignored; the read is accepted and returns 0 with valid asserted.
- dout and dout_samp are forced to 0 whenever their valid is 0, so no stale secret data remains visible.
- Lane select for the sampling read is registered alongside the read, so the output mux stays aligned with the data.
- Reset values: dout=0, dout_samp=0, valid=0, valid_samp=0, busy=0, done=0, FSM=IDLE, cnt=0. Memory contents are not reset.
- Reset mid-CLEAR: the FSM returns to IDLE immediately and no done pulse is produced. Words already cleared stay zero; the remaining words are unchanged.

## Timing
- Read latency: data and valid appear 1 cycle after the accepted strobe (RD_LAT=1). With BIKE_RAM_OUTREG_EN defined, RD_LAT=2.
- Back-to-back reads sustain one read per cycle on the selected port.
- Write takes effect at the strobe edge and is visible to a read issued in the next cycle.
- Zeroize: busy rises the cycle after clear and stays high for exactly DEPTH cycles; done rises in the cycle busy falls.
- A read accepted the cycle before clear still completes with valid asserted. With OUTREG, its pipelined data still emerges.
- Toggling sampling does not cancel reads already in flight; they complete on their original port.

## Configuration
- BIKE_RAM_OUTREG_EN defined: adds an output register stage after the RAM and lane mux (for timing closure at large B_WIDTH). RD_LAT=2; valid and valid_samp are delayed to match.
- Not defined: RD_LAT=1, with the RAM output feeding the lane mux directly.
- All other behaviour is identical in both builds.

## Test plan
- Sampling write then read (B_WIDTH=128): sampling=1, write 32'hA5A5_0001 to addr_samp=6 (word 1, lane 2) → a wide read of addr 1 returns lane2=32'hA5A5_0001 and lanes 0, 1, 3 unchanged, with valid after RD_LAT.
- Wide write then sampling read: sampling=0, write din={32'h4,32'h3,32'h2,32'h1} to addr 5 → sampling reads of addr_samp 20..23 return 1, 2, 3, 4 on consecutive cycles, with valid_samp high continuously.
- Port isolation: sampling=1 with wen=1 to addr 0 → word 0 is unchanged. Read-first: a read and write to the same address in one cycle returns the old value.
- Zeroize (DEPTH=97): fill memory, pulse clear → busy high for 97 cycles, then done for 1 cycle. All reads return 0. Strobes issued during busy give no valid.
- Reset mid-zeroize: assert resetn=0 at cnt=40 → busy=0 and no done. Words 0..39 read 0; word 60 keeps its prior value.
- Out of range: a wide read of addr 100 (DEPTH=97) returns 0 with valid=1; a write to addr 100 leaves all words unchanged. Run with and without BIKE_RAM_OUTREG_EN and check latency 1 and 2 respectively.
